// File: rtl/apb_requester_if.sv
// Command, response and APB bus signals of the APB requester.
// master is the requester side; slave is the command source / completer side.
interface apb_requester_if #(
  parameter int APB_DW = 32,
  parameter int APB_AW = 32
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic              cmd_write;
  logic [APB_AW-1:0] cmd_addr;
  logic [APB_DW-1:0] cmd_wdata;
  logic              rsp_valid;
  logic              rsp_ready;
  logic [APB_DW-1:0] rsp_rdata;
  logic              rsp_err;
  logic              psel;
  logic              penable;
  logic              pwrite;
  logic [APB_AW-1:0] paddr;
  logic [APB_DW-1:0] pwdata;
  logic [APB_DW-1:0] prdata;
  logic              pready;

  modport master (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    input  rsp_ready, prdata, pready,
    output cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    output psel, penable, pwrite, paddr, pwdata
  );

  modport slave (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
    output rsp_ready, prdata, pready,
    input  cmd_ready, rsp_valid, rsp_rdata, rsp_err,
    input  psel, penable, pwrite, paddr, pwdata
  );
endinterface

// File: rtl/apb_requester.sv
// APB initiator: one command at a time through SETUP/ACCESS,
// with pready wait states, an optional timeout and a held response.
module apb_requester #(
  parameter int APB_DW  = 32,
  parameter int APB_AW  = 32,
  parameter int TIMEOUT = 16
) (
  input logic             clk,
  input logic             reset_n,
  apb_requester_if.master bus
);

  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] CNT_LAST =
    CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS
  } state_t;

  state_t            state_q, state_d;
  logic              live_q;
  logic              psel_q, psel_d;
  logic              penable_q, penable_d;
  logic              pwrite_q, pwrite_d;
  logic [APB_AW-1:0] paddr_q, paddr_d;
  logic [APB_DW-1:0] pwdata_q, pwdata_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [APB_DW-1:0] rsp_rdata_q, rsp_rdata_d;
  logic              rsp_err_q, rsp_err_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cmd_ready;
  logic              accept;
  logic              timeout_hit;

  // live_q keeps cmd_ready low until the first clock after reset
  assign cmd_ready = live_q && (state_q == IDLE) &&
                     (!rsp_valid_q || bus.rsp_ready);
  assign accept = bus.cmd_valid && cmd_ready;
  assign timeout_hit = (TIMEOUT != 0) && (cnt_q == CNT_LAST) &&
                       !bus.pready;

  always_comb begin
    state_d     = state_q;
    psel_d      = psel_q;
    penable_d   = penable_q;
    pwrite_d    = pwrite_q;
    paddr_d     = paddr_q;
    pwdata_d    = pwdata_q;
    rsp_valid_d = rsp_valid_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    cnt_d       = cnt_q;
    if (rsp_valid_q && bus.rsp_ready) rsp_valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d   = SETUP;
          psel_d    = 1'b1;
          penable_d = 1'b0;
          pwrite_d  = bus.cmd_write;
          paddr_d   = bus.cmd_addr;
          pwdata_d  = bus.cmd_wdata;
        end
      end
      SETUP: begin
        state_d   = ACCESS;
        penable_d = 1'b1;
        cnt_d     = '0;
      end
      ACCESS: begin
        unique case (1'b1)
          bus.pready: begin
            state_d     = IDLE;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b0;
            rsp_rdata_d = pwrite_q ? '0 : bus.prdata;
          end
          timeout_hit: begin
            state_d     = IDLE;
            psel_d      = 1'b0;
            penable_d   = 1'b0;
            rsp_valid_d = 1'b1;
            rsp_err_d   = 1'b1;
            rsp_rdata_d = '0;
          end
          default: cnt_d = cnt_q + CW'(1);
        endcase
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      live_q      <= 1'b0;
      psel_q      <= 1'b0;
      penable_q   <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      cnt_q       <= '0;
    end else begin
      state_q     <= state_d;
      live_q      <= 1'b1;
      psel_q      <= psel_d;
      penable_q   <= penable_d;
      pwrite_q    <= pwrite_d;
      paddr_q     <= paddr_d;
      pwdata_q    <= pwdata_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      cnt_q       <= cnt_d;
    end
  end

  assign bus.cmd_ready = cmd_ready;
  assign bus.psel      = psel_q;
  assign bus.penable   = penable_q;
  assign bus.pwrite    = pwrite_q;
  assign bus.paddr     = paddr_q;
  assign bus.pwdata    = pwdata_q;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_requester.sv
// Scoreboard bench for apb_requester: completer model with per-transfer
// wait counts, randomized traffic, response backpressure and reset.
module tb_apb_requester;

  localparam int TO = 4;

  typedef struct {
    bit          wr;
    logic [31:0] a;
    logic [31:0] d;
    int          w;
  } cmd_t;

  typedef struct {
    logic [31:0] rdata;
    bit          err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset_n;
  int   cyc = 0;
  int   tests = 0;
  int   fails = 0;
  int   rr_mode = 0;
  int   held = 0;
  bit   seen = 0;
  int   last_acc = 0;

  cmd_t bq[$];
  exp_t sb[$];
  logic [31:0] bfm_mem[logic [31:0]];
  logic [31:0] ref_mem[logic [31:0]];

  apb_requester_if #(.APB_DW(32), .APB_AW(32)) bus ();

  apb_requester #(
    .APB_DW (32),
    .APB_AW (32),
    .TIMEOUT(TO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d",
               name, act, exp, cyc);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return ~a ^ 32'h1357_9BDF;
  endfunction

  // Completer: wait count per transfer comes from the issuing driver.
  cmd_t cur;
  int   rem = 0;
  always @(posedge clk) begin
    #1;
    if (!reset_n) begin
      rem = 0;
      bus.pready = 1'b0;
      bus.prdata = $urandom;
    end else if (bus.psel && !bus.penable) begin
      if (bq.size() == 0) begin
        chk("bfm_unexpected_setup", 64'(bq.size()), 64'd1);
      end else begin
        cur = bq.pop_front();
        rem = cur.w;
        chk("setup_paddr", 64'(bus.paddr), 64'(cur.a));
        chk("setup_pwrite", 64'(bus.pwrite), 64'(cur.wr));
        chk("setup_pwdata", 64'(bus.pwdata), 64'(cur.d));
      end
      bus.pready = 1'($urandom);
      bus.prdata = $urandom;
    end else if (bus.psel && bus.penable) begin
      chk("access_paddr", 64'(bus.paddr), 64'(cur.a));
      chk("access_pwrite", 64'(bus.pwrite), 64'(cur.wr));
      chk("access_pwdata", 64'(bus.pwdata), 64'(cur.d));
      if (rem == 0) begin
        bus.pready = 1'b1;
        if (cur.wr) begin
          bfm_mem[cur.a] = cur.d;
          bus.prdata = $urandom;
        end else begin
          bus.prdata = bfm_mem.exists(cur.a) ? bfm_mem[cur.a]
                                             : dflt(cur.a);
        end
      end else begin
        bus.pready = 1'b0;
        bus.prdata = $urandom;
        rem--;
      end
    end else begin
      bus.pready = 1'($urandom);
      bus.prdata = $urandom;
    end
  end

  always @(posedge clk) begin
    #1;
    if (bus.rsp_valid === 1'b1) held++;
    else held = 0;
    case (rr_mode)
      0: bus.rsp_ready = 1'b1;
      1: bus.rsp_ready = ($urandom % 3) != 0;
      default: bus.rsp_ready = held > 5;
    endcase
  end

  // Monitor: latency on first presentation, payload on consumption.
  exp_t e;
  always @(negedge clk) begin
    if (!reset_n) begin
      seen = 0;
    end else if (bus.rsp_valid) begin
      if (sb.size() == 0) begin
        chk("unexpected_rsp", 64'(bus.rsp_valid), 64'd0);
      end else begin
        if (!seen) begin
          seen = 1;
          chk("rsp_latency", 64'(cyc), 64'(sb[0].cyc));
        end
        if (!bus.rsp_ready) begin
          chk("held_cmd_ready", 64'(bus.cmd_ready), 64'd0);
          chk("held_psel", 64'(bus.psel), 64'd0);
        end else begin
          e = sb.pop_front();
          chk("rsp_rdata", 64'(bus.rsp_rdata), 64'(e.rdata));
          chk("rsp_err", 64'(bus.rsp_err), 64'(e.err));
          seen = 0;
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic issue(input bit wr, input logic [31:0] a,
                       input logic [31:0] d, input int w,
                       input bit chk_gap);
    int   guard;
    exp_t x;
    bit   err;
    guard = 0;
    bus.cmd_valid = 1'b1;
    bus.cmd_write = wr;
    bus.cmd_addr  = a;
    bus.cmd_wdata = d;
    forever begin
      @(negedge clk);
      if (bus.cmd_ready) break;
      guard++;
      if (guard > 60) begin
        chk("cmd_accept_timeout", 64'(guard), 64'd0);
        break;
      end
    end
    if (guard <= 60) begin
      if (chk_gap) chk("b2b_spacing", 64'(cyc - last_acc), 64'd3);
      last_acc = cyc;
      err = (w >= TO);
      x.err = err;
      x.cyc = cyc + 3 + (err ? TO - 1 : w);
      x.rdata = 32'h0;
      if (!err && wr) ref_mem[a] = d;
      if (!err && !wr)
        x.rdata = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
      sb.push_back(x);
      bq.push_back('{wr: wr, a: a, d: d, w: w});
    end
    @(posedge clk);
    #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic drain();
    int guard;
    guard = 0;
    forever begin
      @(negedge clk);
      if (sb.size() == 0 && !bus.rsp_valid) break;
      guard++;
      if (guard > 200) begin
        chk("drain_timeout", 64'(sb.size()), 64'd0);
        sb.delete();
        bq.delete();
        break;
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    bus.cmd_valid = 1'b0;
    bus.cmd_write = 1'b0;
    bus.cmd_addr  = '0;
    bus.cmd_wdata = '0;
    bfm_mem[32'h20] = 32'hDEAD_BEEF;
    ref_mem[32'h20] = 32'hDEAD_BEEF;
    #3;
    chk("rst_psel", 64'(bus.psel), 64'd0);
    chk("rst_penable", 64'(bus.penable), 64'd0);
    chk("rst_paddr", 64'(bus.paddr), 64'd0);
    chk("rst_pwdata", 64'(bus.pwdata), 64'd0);
    chk("rst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("rst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("post_rst_cmd_ready", 64'(bus.cmd_ready), 64'd1);

    rr_mode = 0;
    issue(1'b1, 32'h10, 32'hA5A5_5A5A, 0, 1'b0);
    drain();
    issue(1'b0, 32'h20, 32'h0, 3, 1'b0);
    drain();
    issue(1'b0, 32'h4, 32'h0, 6, 1'b0);
    drain();
    issue(1'b1, 32'h8, 32'h1111_2222, 4, 1'b0);
    drain();
    issue(1'b0, 32'h8, 32'h0, 0, 1'b0);
    drain();

    rr_mode = 2;
    issue(1'b0, 32'h10, 32'h0, 1, 1'b0);
    issue(1'b1, 32'hC, 32'hCAFE_F00D, 0, 1'b0);
    issue(1'b0, 32'hC, 32'h0, 2, 1'b0);
    drain();

    rr_mode = 0;
    issue(1'b1, 32'h14, 32'h0BAD_0001, 0, 1'b0);
    issue(1'b0, 32'h14, 32'h0, 0, 1'b1);
    issue(1'b1, 32'h18, 32'h0BAD_0002, 0, 1'b1);
    issue(1'b0, 32'h18, 32'h0, 0, 1'b1);
    drain();

    for (int i = 0; i < 60; i++) begin
      if (i % 20 == 0) rr_mode = int'($urandom % 3);
      repeat ($urandom % 3) begin
        @(posedge clk);
        #1;
      end
      issue(1'($urandom), {27'h0, 3'($urandom), 2'b00}, $urandom,
            int'($urandom % 7), 1'b0);
    end
    drain();

    rr_mode = 0;
    issue(1'b1, 32'h1C, 32'h7777_7777, 6, 1'b0);
    begin
      int guard;
      guard = 0;
      forever begin
        @(negedge clk);
        if (bus.psel && bus.penable) break;
        guard++;
        if (guard > 10) begin
          chk("reach_access_timeout", 64'(guard), 64'd0);
          break;
        end
      end
    end
    #2;
    reset_n = 1'b0;
    #1;
    chk("midrst_psel", 64'(bus.psel), 64'd0);
    chk("midrst_penable", 64'(bus.penable), 64'd0);
    chk("midrst_rsp_valid", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_cmd_ready", 64'(bus.cmd_ready), 64'd0);
    bq.delete();
    sb.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst_cmd_ready_after", 64'(bus.cmd_ready), 64'd1);
    repeat (10) @(posedge clk);
    #1;
    chk("midrst_no_rsp", 64'(bus.rsp_valid), 64'd0);
    chk("midrst_bus_idle", 64'(bus.psel), 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
